// File: rtl/alu_seq.sv
// alu_seq: multi-cycle integer ALU.
// ADD/SUB/MOV/shift/boolean ops complete on the accepting edge. MUL runs an
// iterative shift-add engine and DIV a restoring divider, each DATA_W cycles.
// The op codes match the shared command encoding (CMD_MOV .. CMD_OR).
//
// Handshake: start is a request sampled only on an enabled edge (clk_oe=1)
// while the FSM is in IDLE. The accepting edge raises busy for multi-cycle
// ops. The edge that enters DONE drops busy and raises done for one enabled
// cycle, with dst/dst_h/div_zero/illegal valid while done=1. start is ignored
// while busy or done is high. Nothing moves on edges where clk_oe=0.
module alu_seq #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clk_oe,
    input  logic              start,
    input  logic [3:0]        op,
    input  logic [DATA_W-1:0] src0,
    input  logic [DATA_W-1:0] src1,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] dst,
    output logic [DATA_W-1:0] dst_h,
    output logic              div_zero,
    output logic              illegal,
    output logic [1:0]        state_dbg
);

    localparam logic [3:0] OP_MOV = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_MUL = 4'd3;
    localparam logic [3:0] OP_DIV = 4'd4;
    localparam logic [3:0] OP_SHR = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_XOR = 4'd7;
    localparam logic [3:0] OP_AND = 4'd8;
    localparam logic [3:0] OP_OR  = 4'd9;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              state;
    logic [CNT_W-1:0]    cnt;
    logic [2*DATA_W-1:0] acc;
    logic [2*DATA_W-1:0] mcand;
    logic [DATA_W-1:0]   mplier;
    logic [DATA_W-1:0]   divisor;
    logic [DATA_W-1:0]   rem;
    logic [DATA_W-1:0]   quot;

    logic [2*DATA_W-1:0] single_res;
    logic                single_ok;
    logic [2*DATA_W-1:0] acc_nxt;
    logic [DATA_W:0]     trial;
    logic [DATA_W:0]     trial_diff;
    logic                trial_ge;
    logic [DATA_W-1:0]   rem_nxt;
    logic [DATA_W-1:0]   quot_nxt;

    assign state_dbg = state;

    // Single-cycle results, computed straight from the live operands at accept.
    always_comb begin
        single_res = '0;
        single_ok  = 1'b1;
        case (op)
            OP_MOV: single_res = {src1, src0};
            OP_ADD: single_res = {{DATA_W{1'b0}}, src0} + {{DATA_W{1'b0}}, src1};
            OP_SUB: single_res = {{DATA_W{1'b0}}, src0} - {{DATA_W{1'b0}}, src1};
            OP_SHR: single_res = {{DATA_W{1'b0}}, src0 >> src1};
            OP_SHL: single_res = {{DATA_W{1'b0}}, src0 << src1};
            OP_XOR: single_res = {{DATA_W{1'b0}}, src0 ^ src1};
            OP_AND: single_res = {{DATA_W{1'b0}}, src0 & src1};
            OP_OR:  single_res = {{DATA_W{1'b0}}, src0 | src1};
            default: single_ok = 1'b0;
        endcase
    end

    // One iteration of the shift-add multiplier and of the restoring divider.
    always_comb begin
        acc_nxt    = mplier[0] ? (acc + mcand) : acc;
        trial      = {rem, quot[DATA_W-1]};
        trial_diff = trial - {1'b0, divisor};
        trial_ge   = (trial >= {1'b0, divisor});
        rem_nxt    = trial_ge ? trial_diff[DATA_W-1:0] : trial[DATA_W-1:0];
        quot_nxt   = {quot[DATA_W-2:0], trial_ge};
    end

    // Control FSM with registered outputs; dst/dst_h only change on DONE entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            divisor  <= '0;
            rem      <= '0;
            quot     <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            dst      <= '0;
            dst_h    <= '0;
            div_zero <= 1'b0;
            illegal  <= 1'b0;
        end else if (clk_oe) begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        div_zero <= 1'b0;
                        illegal  <= 1'b0;
                        cnt      <= '0;
                        if (op == OP_MUL) begin
                            acc    <= '0;
                            mcand  <= {{DATA_W{1'b0}}, src0};
                            mplier <= src1;
                            busy   <= 1'b1;
                            state  <= S_MUL;
                        end else if (op == OP_DIV) begin
                            if (src1 == '0) begin
                                dst      <= '1;
                                dst_h    <= src0;
                                div_zero <= 1'b1;
                                done     <= 1'b1;
                                state    <= S_DONE;
                            end else begin
                                rem     <= '0;
                                quot    <= src0;
                                divisor <= src1;
                                busy    <= 1'b1;
                                state   <= S_DIV;
                            end
                        end else if (single_ok) begin
                            {dst_h, dst} <= single_res;
                            done         <= 1'b1;
                            state        <= S_DONE;
                        end else begin
                            illegal <= 1'b1;
                            done    <= 1'b1;
                            state   <= S_DONE;
                        end
                    end
                end
                S_MUL: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        {dst_h, dst} <= acc_nxt;
                        busy         <= 1'b0;
                        done         <= 1'b1;
                        state        <= S_DONE;
                    end
                end
                S_DIV: begin
                    rem  <= rem_nxt;
                    quot <= quot_nxt;
                    cnt  <= cnt + CNT_W'(1);
                    if (cnt == CNT_LAST) begin
                        dst   <= quot_nxt;
                        dst_h <= rem_nxt;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
